alu_req_driver: RTL and testbench

- Initiator-side companion to the registered 8-bit add/sub ALU in this codebase.
- Accepts operation commands on a valid/ready interface and drives them to the ALU as a `port` struct (control_in, a_in, b_in).
- Captures the ALU's `o_port` result (result_out, flag_out) after a fixed latency and returns it on a valid/ready response interface.
- Self-checks each result against an internally computed expected value and keeps saturating op and error counters.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_req_driver_sat_counter.sv | 26 ++
 rtl/alu_req_driver.sv | 122 ++++++++++++
 tb/tb_alu_req_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the 8-bit add/sub ALU and its request driver.
//   port    : request bundle into the ALU (control_in = 1 selects subtract)
//   o_port  : registered ALU result ({flag_out, result_out})
//   IDLE/ISSUE/WAIT/RESP : driver FSM state encodings
//   alu_expected(sub, a, b) : reference 9-bit {flag, result} for one operation
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef struct packed {
        logic       control_in;
        logic [7:0] a_in;
        logic [7:0] b_in;
    } port;

    typedef struct packed {
        logic       flag_out;
        logic [7:0] result_out;
    } o_port;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Add: bit 8 is the carry-out. Sub: the 9-bit wrap sets bit 8 exactly
    // when a < b, which is the ALU's borrow flag.
    function automatic logic [8:0] alu_expected(input logic       sub,
                                                input logic [7:0] a,
                                                input logic [7:0] b);
        logic [8:0] ext_a;
        logic [8:0] ext_b;
        ext_a = {1'b0, a};
        ext_b = {1'b0, b};
        return sub ? (ext_a - ext_b) : (ext_a + ext_b);
    endfunction

endpackage

// File: rtl/alu_req_driver_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clock : rising-edge clock
//   clr   : synchronous clear, takes priority over inc
//   inc   : count one event this cycle
//   count : current value, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_req_driver.sv
// -----------------------------------------------------------------------------
// alu_req_driver
// Takes add/sub commands on a valid/ready interface, drives them to the
// registered ALU, captures the result after ALU_LATENCY cycles, checks it
// against a locally computed reference and returns it on a valid/ready
// response interface. Keeps saturating counts of responses and mismatches.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake; cmd_sub/cmd_a/cmd_b operands
//   alu_req                 : registered request to the ALU
//   alu_rsp                 : registered result from the ALU
//   rsp_valid/rsp_ready     : response handshake
//   rsp_result/rsp_flag     : captured ALU result
//   rsp_mismatch            : captured result differs from the reference
//   op_count/err_count      : saturating response / mismatch counters
//   busy                    : FSM is not idle
// -----------------------------------------------------------------------------
module alu_req_driver
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16,
    parameter int CHECK_EN    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sub,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output port              alu_req,
    input  o_port            alu_rsp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_flag,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [8:0]        expected;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              check_on;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign check_on  = (CHECK_EN != 0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            alu_req      <= '0;
            expected     <= '0;
            wait_cnt     <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flag     <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // alu_req is only written here, so operands stay stable
                    // for the whole operation.
                    if (cmd_fire) begin
                        alu_req  <= '{control_in: cmd_sub, a_in: cmd_a, b_in: cmd_b};
                        expected <= alu_expected(cmd_sub, cmd_a, cmd_b);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_W'(ALU_LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_result   <= alu_rsp.result_out;
                        rsp_flag     <= alu_rsp.flag_out;
                        rsp_mismatch <= check_on &&
                                        ({alu_rsp.flag_out, alu_rsp.result_out} != expected);
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counters clear on reset with priority, so a handshake coinciding with
    // reset is never counted.
    sat_counter #(.W(CNT_W)) u_op_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (rsp_fire),
        .count (op_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (rsp_fire && rsp_mismatch),
        .count (err_count)
    );

endmodule

// File: tb/tb_alu_req_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_req_driver
// Three driver instances run in lockstep on one command stream: default
// configuration, CHECK_EN = 0, and CNT_W = 2. A registered ALU model (with an
// optional forced wrong result) answers the default instance's requests.
// Expected responses are pushed at command issue and popped by a monitor on
// every response handshake.
// -----------------------------------------------------------------------------
module tb_alu_req_driver;
    import alu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_sub;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_ready;
    logic       fault;

    o_port      alu_q;
    o_port      alu_rsp;
    logic [8:0] alu_r;

    port        m_alu_req, n_alu_req, s_alu_req;
    logic       m_cmd_ready, n_cmd_ready, s_cmd_ready;
    logic       m_rsp_valid, n_rsp_valid, s_rsp_valid;
    logic [7:0] m_rsp_result, n_rsp_result, s_rsp_result;
    logic       m_rsp_flag, n_rsp_flag, s_rsp_flag;
    logic       m_rsp_mismatch, n_rsp_mismatch, s_rsp_mismatch;
    logic [15:0] m_op_count, m_err_count, n_op_count, n_err_count;
    logic [1:0]  s_op_count, s_err_count;
    logic       m_busy, n_busy, s_busy;

    typedef struct packed {
        logic [7:0] res;
        logic       flag;
        logic       mm;
    } exp_t;

    exp_t sbq[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    logic prev_valid = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Registered add/sub ALU model, latency 1.
    assign alu_r   = m_alu_req.control_in ? ({1'b0, m_alu_req.a_in} - {1'b0, m_alu_req.b_in})
                                          : ({1'b0, m_alu_req.a_in} + {1'b0, m_alu_req.b_in});
    always @(posedge clock) alu_q <= '{flag_out: alu_r[8], result_out: alu_r[7:0]};
    assign alu_rsp = fault ? o_port'{flag_out: 1'b0, result_out: 8'h11} : alu_q;

    alu_req_driver dut_m (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(m_cmd_ready),
        .cmd_sub(cmd_sub), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_req(m_alu_req),
        .alu_rsp(alu_rsp), .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(m_rsp_result), .rsp_flag(m_rsp_flag), .rsp_mismatch(m_rsp_mismatch),
        .op_count(m_op_count), .err_count(m_err_count), .busy(m_busy)
    );

    alu_req_driver #(.CHECK_EN(0)) dut_n (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
        .cmd_sub(cmd_sub), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_req(n_alu_req),
        .alu_rsp(alu_rsp), .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(n_rsp_result), .rsp_flag(n_rsp_flag), .rsp_mismatch(n_rsp_mismatch),
        .op_count(n_op_count), .err_count(n_err_count), .busy(n_busy)
    );

    alu_req_driver #(.CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_sub(cmd_sub), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_req(s_alu_req),
        .alu_rsp(alu_rsp), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(s_rsp_result), .rsp_flag(s_rsp_flag), .rsp_mismatch(s_rsp_mismatch),
        .op_count(s_op_count), .err_count(s_err_count), .busy(s_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (m_rsp_valid && !prev_valid)
                chk("rsp_latency", cyc, accept_cyc + 3);
            if (m_rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_result", m_rsp_result, e.res);
                    chk("rsp_flag", m_rsp_flag, e.flag);
                    chk("rsp_mismatch", m_rsp_mismatch, e.mm);
                    chk("nochk_mismatch", n_rsp_mismatch, 0);
                    chk("nochk_result", n_rsp_result, e.res);
                    chk("sat_valid", s_rsp_valid, 1);
                    chk("sat_result", s_rsp_result, e.res);
                end
            end
            prev_valid = m_rsp_valid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    task automatic do_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ef, input logic emm,
                         input logic flt);
        cmd_sub   = sub;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        fault     = flt;
        chk("cmd_ready_idle", m_cmd_ready, 1);
        sbq.push_back('{res: er, flag: ef, mm: emm});
        accept_cyc = cyc;
        tick();
        cmd_valid = 1'b0;
        wait_drain();
        fault = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_sub = 1'b0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1; fault = 1'b0;
        tick(); tick();
        chk("rst_busy", m_busy, 0);
        chk("rst_rsp_valid", m_rsp_valid, 0);
        chk("rst_cmd_ready", m_cmd_ready, 1);
        chk("rst_alu_req", m_alu_req, 0);
        chk("rst_rsp_result", m_rsp_result, 0);
        chk("rst_op_count", m_op_count, 0);
        chk("rst_err_count", m_err_count, 0);
        reset = 1'b0;
        tick();

        // Basic operations
        do_op(1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0);
        chk("op_count_1", m_op_count, 1);
        do_op(1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0);
        do_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("op_count_3", m_op_count, 3);
        chk("err_count_0", m_err_count, 0);

        // Forced wrong ALU result
        do_op(1'b0, 8'h0F, 8'h01, 8'h11, 1'b0, 1'b1, 1'b1);
        chk("err_count_fault", m_err_count, 1);
        chk("nochk_err_count", n_err_count, 0);
        chk("op_count_4", m_op_count, 4);
        chk("sat_op_count_4", s_op_count, 3);
        chk("sat_err_count", s_err_count, 1);

        // Backpressure with a second command waiting
        rsp_ready = 1'b0;
        cmd_sub = 1'b0; cmd_a = 8'h12; cmd_b = 8'h34; cmd_valid = 1'b1;
        chk("bp_cmd_ready", m_cmd_ready, 1);
        sbq.push_back('{res: 8'h46, flag: 1'b0, mm: 1'b0});
        accept_cyc = cyc;
        tick();
        cmd_sub = 1'b1; cmd_a = 8'h50; cmd_b = 8'h10;
        begin
            int n = 0;
            while (!m_rsp_valid && n < 20) begin
                tick();
                n++;
            end
            chk("bp_valid_timeout", m_rsp_valid, 1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", m_rsp_valid, 1);
            chk("bp_hold_result", m_rsp_result, 8'h46);
            chk("bp_hold_flag", m_rsp_flag, 0);
            chk("bp_cmd_blocked", m_cmd_ready, 0);
            chk("bp_req_stable", m_alu_req, {1'b0, 8'h12, 8'h34});
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_after_hs", m_cmd_ready, 1);
        chk("bp_op_count_5", m_op_count, 5);
        sbq.push_back('{res: 8'h40, flag: 1'b0, mm: 1'b0});
        accept_cyc = cyc;
        tick();
        chk("bp_second_accepted", m_busy, 1);
        chk("bp_second_req", m_alu_req, {1'b1, 8'h50, 8'h10});
        cmd_valid = 1'b0;
        wait_drain();
        chk("op_count_6", m_op_count, 6);
        chk("sat_op_count_6", s_op_count, 3);

        // Reset while waiting on the ALU
        cmd_sub = 1'b0; cmd_a = 8'h01; cmd_b = 8'h02; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("wait_busy", m_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_rsp_valid", m_rsp_valid, 0);
        chk("mid_rst_op_count", m_op_count, 0);
        chk("mid_rst_err_count", m_err_count, 0);
        chk("mid_rst_cmd_ready", m_cmd_ready, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("no_stale_rsp", m_rsp_valid, 0);

        do_op(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_rst_op_count", m_op_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
